// File: rtl/warn_display_arbiter_if.sv
// Warning display arbiter bus: detector requests and driver ack in, display/buzzer out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the requester modport sees level outputs, the arbiter modport owns them.
// Ports: warn_req/ack driven by the requester side; display_valid, display_idx,
//        buzzer and pending driven by the arbiter side.
interface warn_display_arbiter_if #(
  parameter int NUM_WARN = 4,
  parameter int IDX_W    = 2
);
  logic [NUM_WARN-1:0] warn_req;
  logic                ack;
  logic                display_valid;
  logic [IDX_W-1:0]    display_idx;
  logic                buzzer;
  logic [NUM_WARN-1:0] pending;

  // Requester side: warning detectors plus driver acknowledge.
  modport master (
    output warn_req,
    output ack,
    input  display_valid,
    input  display_idx,
    input  buzzer,
    input  pending
  );

  // Arbiter side.
  modport slave (
    input  warn_req,
    input  ack,
    output display_valid,
    output display_idx,
    output buzzer,
    output pending
  );
endinterface

// File: rtl/warn_display_arbiter.sv
// Shares one dashboard warning display and buzzer among NUM_WARN level warnings, round-robin.
// Latency: 1 cycle from warn_req/ack sampling to registered outputs.
// Backpressure: none; each shown warning holds the display for exactly HOLD_CYCLES cycles.
// Ports: clock, reset (async active-low); bus.slave carries warn_req, ack in and
//        display_valid, display_idx, buzzer, pending out (all outputs registered).
module warn_display_arbiter #(
  parameter int NUM_WARN    = 4,
  parameter int IDX_W       = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  warn_display_arbiter_if.slave  bus
);

  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_WARN-1:0] req_q;
  logic [NUM_WARN-1:0] pend_q, pend_d;
  logic                buzz_q;
  logic [NUM_WARN-1:0] rise;
  logic                any_req;
  logic [IDX_W-1:0]    lowest_idx;
  logic [IDX_W-1:0]    next_idx;
  logic [IDX_W-1:0]    probe;

  assign any_req = |bus.warn_req;

  // Lowest set request, used when starting from IDLE.
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_WARN - 1; i >= 0; i--) begin
      if (bus.warn_req[i]) lowest_idx = IDX_W'(i);
    end
  end

  // Next set request after the current one, wrapping. The distance loop runs
  // from far to near so the nearest hit wins; distance NUM_WARN is the current
  // index itself, which therefore only wins when it is the sole request.
  always_comb begin
    next_idx = idx_q;
    probe    = '0;
    for (int k = NUM_WARN; k >= 1; k--) begin
      probe = IDX_W'((int'(idx_q) + k) % NUM_WARN);
      if (bus.warn_req[probe]) next_idx = probe;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        idx_d = '0;
        if (any_req) begin
          state_d = SHOW;
          vld_d   = 1'b1;
          idx_d   = lowest_idx;
          cnt_d   = HOLD_M1;
        end
      end
      SHOW: begin
        // The slot always runs to completion, even if its request drops.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (any_req) begin
          idx_d = next_idx;
          cnt_d = HOLD_M1;
        end else begin
          state_d = IDLE;
          vld_d   = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // A rising edge coinciding with ack survives the clear for that bit.
  assign rise   = bus.warn_req & ~req_q;
  assign pend_d = bus.ack ? rise : (pend_q | rise);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      req_q   <= '0;
      pend_q  <= '0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      req_q   <= bus.warn_req;
      pend_q  <= pend_d;
      buzz_q  <= |pend_d;
    end
  end

  assign bus.display_valid = vld_q;
  assign bus.display_idx   = idx_q;
  assign bus.pending       = pend_q;
  assign bus.buzzer        = buzz_q;

endmodule

// File: tb/tb_warn_display_arbiter.sv
// Bench for warn_display_arbiter: directed scenarios then random requests/acks/resets.
// Latency: compares every cycle, 1 ns after the rising edge, against a slot-level model.
// Backpressure: n/a.
module tb_warn_display_arbiter;

  localparam int NW   = 4;
  localparam int HOLD = 8;

  logic clock;
  logic reset;

  warn_display_arbiter_if #(.NUM_WARN(NW), .IDX_W(2)) bus ();

  warn_display_arbiter #(.NUM_WARN(NW), .IDX_W(2), .HOLD_CYCLES(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: which warning occupies the display and how many of its
  // cycles remain, plus the set of unacknowledged warnings.
  bit          m_show;
  int          m_idx;
  int          m_left;
  logic [NW-1:0] m_prev;
  logic [NW-1:0] m_pend;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_of(input logic [NW-1:0] r);
    for (int i = 0; i < NW; i++) if (r[i]) return i;
    return 0;
  endfunction

  function automatic int next_after(input int cur, input logic [NW-1:0] r);
    for (int k = 1; k <= NW; k++) if (r[(cur + k) % NW]) return (cur + k) % NW;
    return cur;
  endfunction

  task automatic model_reset();
    m_show = 0;
    m_idx  = 0;
    m_left = 0;
    m_prev = '0;
    m_pend = '0;
  endtask

  task automatic model_edge(input logic [NW-1:0] r, input logic a);
    logic [NW-1:0] new_bits;
    new_bits = r & ~m_prev;
    m_prev   = r;
    if (a) m_pend = new_bits;
    else   m_pend = m_pend | new_bits;
    if (!m_show) begin
      if (r != 0) begin
        m_show = 1;
        m_idx  = lowest_of(r);
        m_left = HOLD;
      end
    end else if (m_left > 1) begin
      m_left--;
    end else if (r != 0) begin
      m_idx  = next_after(m_idx, r);
      m_left = HOLD;
    end else begin
      m_show = 0;
      m_idx  = 0;
    end
  endtask

  task automatic compare_all();
    check_val("display_valid", 32'(bus.display_valid), 32'(m_show));
    check_val("display_idx",   32'(bus.display_idx),   32'(m_idx));
    check_val("pending",       32'(bus.pending),       32'(m_pend));
    check_val("buzzer",        32'(bus.buzzer),        32'(|m_pend));
  endtask

  // One clock: model follows the edge using the inputs held across it.
  task automatic step();
    logic [NW-1:0] r;
    logic a;
    r = bus.warn_req;
    a = bus.ack;
    @(posedge clock);
    if (reset) model_edge(r, a);
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  // Assert reset between edges, confirm outputs clear without a clock edge,
  // hold it for two edges, then release with the given request pattern.
  task automatic async_reset(input logic [NW-1:0] req_at_release);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    steps(2);
    bus.warn_req = req_at_release;
    reset = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * HOLD && m_show; i++) step();
    check_val("reach_idle", 32'(m_show), 32'd0);
  endtask

  initial begin
    model_reset();
    reset        = 1'b0;
    bus.warn_req = 4'b0010;
    bus.ack      = 1'b0;
    #1;
    compare_all();
    steps(3);
    reset = 1'b1;

    // Request held through reset release is a new warning.
    step();
    check_val("rel_idx1", 32'(bus.display_idx), 32'd1);
    steps(HOLD);

    // Single steady request: continuous display, no gap at slot boundaries.
    bus.warn_req = 4'b0100;
    steps(40);

    // Two requests alternate with wrap.
    bus.warn_req = 4'b1010;
    steps(3 * HOLD + 4);

    // Short pulse from IDLE still gets a full slot.
    bus.warn_req = 4'b0000;
    ack_pulse();
    wait_idle();
    bus.warn_req = 4'b0010;
    steps(2);
    bus.warn_req = 4'b0000;
    steps(HOLD + 4);
    check_val("pend_hold", 32'(bus.pending), 32'b0010);

    // Ack clears; ack coinciding with a rise keeps that bit.
    ack_pulse();
    bus.warn_req = 4'b0100;
    steps(3);
    ack_pulse();
    bus.warn_req = 4'b0101;
    ack_pulse();
    check_val("ack_rise", 32'(bus.pending), 32'b0001);

    // Reset during a slot, release with the top warning requested.
    bus.warn_req = 4'b0000;
    ack_pulse();
    wait_idle();
    bus.warn_req = 4'b0100;
    steps(3);
    async_reset(4'b1000);
    step();
    check_val("rst_idx3", 32'(bus.display_idx), 32'd3);
    steps(HOLD + 2);

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) bus.warn_req = '0;
        else bus.warn_req = 4'($urandom_range(0, 15));
      end
      bus.ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) async_reset(4'($urandom_range(0, 15)));
      else step();
    end
    bus.ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
